// File: rtl/model_lstm_controller_pkg.sv
// Shared widths and the transmitter FSM state type for the LSTM vector path.
package model_lstm_controller_pkg;

  localparam int DATA_SIZE    = 64;
  localparam int CONTROL_SIZE = 64;
  localparam int BUFFER_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE_STATE    = 2'd0,
    REQUEST_STATE = 2'd1,
    SEND_STATE    = 2'd2,
    END_STATE     = 2'd3
  } state_t;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/model_vector_buffer.sv
// Vector storage: one write port, one read port whose address is registered,
// so rd_data follows the address presented on the previous clock edge.
module model_vector_buffer #(
  parameter int DATA_SIZE    = 64,
  parameter int BUFFER_DEPTH = 16,
  parameter int ADDR_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [DATA_SIZE-1:0] rd_data
);

  logic [DATA_SIZE-1:0] mem [BUFFER_DEPTH];
  logic [ADDR_W-1:0]    rd_addr_q;

  // Contents are deliberately not reset; stale data is never read back.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q <= '0;
    end else begin
      rd_addr_q <= rd_addr;
    end
  end

  assign rd_data = mem[rd_addr_q];

endmodule

// File: rtl/model_lstm_vector_transmitter.sv
// Loads a vector into a local buffer, then hands it element by element to the
// LSTM controller on request, pulsing READY at the end or ERROR on a bad START.
module model_lstm_vector_transmitter
  import model_lstm_controller_pkg::*;
#(
  parameter int DATA_SIZE    = model_lstm_controller_pkg::DATA_SIZE,
  parameter int CONTROL_SIZE = model_lstm_controller_pkg::CONTROL_SIZE,
  parameter int BUFFER_DEPTH = model_lstm_controller_pkg::BUFFER_DEPTH
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic [CONTROL_SIZE-1:0] SIZE_IN,
  input  logic                    LOAD_ENABLE,
  input  logic [DATA_SIZE-1:0]    LOAD_DATA,
  input  logic                    DATA_ENABLE,
  output logic                    DATA_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    DATA_OUT,
  output logic                    LOAD_FULL,
  output logic                    READY,
  output logic                    ERROR,
  output state_t                  DEBUG_STATE
);

  localparam int ADDR_W = addr_width(BUFFER_DEPTH);
  localparam logic [CONTROL_SIZE-1:0] DEPTH_C = CONTROL_SIZE'(BUFFER_DEPTH);
  localparam logic [CONTROL_SIZE-1:0] ONE_C   = CONTROL_SIZE'(1);

  // Handshake: DATA_ENABLE is a request that only counts in REQUEST_STATE;
  // each accepted request yields exactly one DATA_OUT_ENABLE cycle on the
  // following clock, and DATA_OUT holds its value whenever that strobe is low.

  state_t                  state_q, state_d;
  logic [CONTROL_SIZE-1:0] count_q, count_d;
  logic [CONTROL_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [CONTROL_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [CONTROL_SIZE-1:0] length_q, length_d;
  logic [DATA_SIZE-1:0]    data_out_q, data_out_d;
  logic                    data_out_en_q, data_out_en_d;
  logic                    full_q, full_d;
  logic                    ready_q, ready_d;
  logic                    error_q, error_d;
  logic                    load_ok;
  logic [DATA_SIZE-1:0]    rd_data;

  model_vector_buffer #(
    .DATA_SIZE    (DATA_SIZE),
    .BUFFER_DEPTH (BUFFER_DEPTH),
    .ADDR_W       (ADDR_W)
  ) u_buffer (
    .clk     (CLK),
    .rst_n   (RST),
    .wr_en   (load_ok),
    .wr_addr (wr_ptr_q[ADDR_W-1:0]),
    .wr_data (LOAD_DATA),
    .rd_addr (rd_ptr_d[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    length_d      = length_q;
    data_out_d    = data_out_q;
    data_out_en_d = 1'b0;
    ready_d       = 1'b0;
    error_d       = 1'b0;
    load_ok       = 1'b0;

    case (state_q)
      IDLE_STATE: begin
        load_ok = LOAD_ENABLE && (count_q < DEPTH_C);
        if (load_ok) begin
          wr_ptr_d = wr_ptr_q + ONE_C;
          count_d  = count_q + ONE_C;
        end
        // The length check sees a load arriving in the same cycle.
        if (START) begin
          if ((SIZE_IN == '0) || (SIZE_IN > count_d)) begin
            error_d = 1'b1;
          end else begin
            length_d = SIZE_IN;
            rd_ptr_d = '0;
            state_d  = REQUEST_STATE;
          end
        end
      end
      REQUEST_STATE: begin
        if (DATA_ENABLE) begin
          data_out_d    = rd_data;
          data_out_en_d = 1'b1;
          state_d       = SEND_STATE;
        end
      end
      SEND_STATE: begin
        rd_ptr_d = rd_ptr_q + ONE_C;
        if (rd_ptr_d == length_q) begin
          ready_d  = 1'b1;
          count_d  = '0;
          wr_ptr_d = '0;
          state_d  = END_STATE;
        end else begin
          state_d = REQUEST_STATE;
        end
      end
      END_STATE: begin
        state_d = IDLE_STATE;
      end
      default: begin
        state_d = IDLE_STATE;
      end
    endcase

    full_d = (count_d == DEPTH_C);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE_STATE;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      length_q      <= '0;
      data_out_q    <= '0;
      data_out_en_q <= 1'b0;
      full_q        <= 1'b0;
      ready_q       <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      length_q      <= length_d;
      data_out_q    <= data_out_d;
      data_out_en_q <= data_out_en_d;
      full_q        <= full_d;
      ready_q       <= ready_d;
      error_q       <= error_d;
    end
  end

  assign DATA_OUT_ENABLE = data_out_en_q;
  assign DATA_OUT        = data_out_q;
  assign LOAD_FULL       = full_q;
  assign READY           = ready_q;
  assign ERROR           = error_q;
  assign DEBUG_STATE     = state_q;

endmodule

// File: doc/model_lstm_vector_transmitter.md
MODEL_LSTM_VECTOR_TRANSMITTER -- requirements
Module: model_lstm_vector_transmitter

Interface
REQ-001 Parameter DATA_SIZE, default 64, element width in bits (fixed-point word).
REQ-002 Parameter CONTROL_SIZE, default 64, width of length and count fields.
REQ-003 Parameter BUFFER_DEPTH, default 16, maximum vector length held.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 CLK  in  1  clock; all state changes on its rising edge.
REQ-006 RST  in  1  asynchronous, active-low reset.
REQ-007 START  in  1  begin transmitting the loaded vector.
REQ-008 SIZE_IN  in  CONTROL_SIZE  number of elements to transmit.
REQ-009 LOAD_ENABLE  in  1  write LOAD_DATA into the next free buffer slot.
REQ-010 LOAD_DATA  in  DATA_SIZE  element to load.
REQ-011 DATA_ENABLE  in  1  consumer (LSTM controller) requests the next element.
REQ-012 DATA_OUT_ENABLE  out  1  DATA_OUT holds a valid element this cycle.
REQ-013 DATA_OUT  out  DATA_SIZE  transmitted element.
REQ-014 LOAD_FULL  out  1  buffer holds BUFFER_DEPTH elements.
REQ-015 READY  out  1  one-cycle pulse: transmission complete.
REQ-016 ERROR  out  1  one-cycle pulse: START rejected.

Function
REQ-017 The FSM SHALL have states IDLE_STATE, REQUEST_STATE, SEND_STATE, END_STATE.
REQ-018 In IDLE_STATE, LOAD_ENABLE=1 SHALL write LOAD_DATA at the write pointer and increment the load count; LOAD_FULL SHALL be 1 while count==BUFFER_DEPTH.
REQ-019 A load attempted at count==BUFFER_DEPTH, or in any state other than IDLE_STATE, SHALL be ignored with no other effect.
REQ-020 START in IDLE_STATE SHALL be checked against the count including any simultaneous load; if SIZE_IN==0 or SIZE_IN>count, ERROR SHALL pulse 1 cycle and the FSM SHALL stay in IDLE_STATE.
REQ-021 An accepted START SHALL latch SIZE_IN, clear the read pointer and enter REQUEST_STATE on the next edge.
REQ-022 START outside IDLE_STATE SHALL be ignored; DATA_ENABLE outside REQUEST_STATE SHALL be ignored.
REQ-023 In REQUEST_STATE, DATA_ENABLE sampled 1 SHALL move the FSM to SEND_STATE; in SEND_STATE DATA_OUT=buffer[read pointer] and DATA_OUT_ENABLE=1 for exactly one cycle.
REQ-024 Leaving SEND_STATE, the read pointer SHALL increment; if the element sent was index length-1 the FSM SHALL enter END_STATE, else REQUEST_STATE.
REQ-025 With DATA_ENABLE held high, elements SHALL be emitted one every 2 cycles; first DATA_OUT_ENABLE appears 1 cycle after DATA_ENABLE is sampled in REQUEST_STATE.
REQ-026 In END_STATE, READY=1 for one cycle, load count and write pointer SHALL clear, LOAD_FULL SHALL drop, and the FSM SHALL return to IDLE_STATE.
REQ-027 DATA_OUT SHALL hold its last value while DATA_OUT_ENABLE=0.
REQ-028 Pointers SHALL be CONTROL_SIZE wide; no wrap-around occurs since length<=BUFFER_DEPTH.

Reset
REQ-029 RST=0 SHALL asynchronously force IDLE_STATE, all outputs to 0, pointers and count to 0.
REQ-030 Reset mid-transmission SHALL abandon the vector without READY; buffer contents need not be cleared.

Structure
REQ-031 DATA_SIZE, CONTROL_SIZE, BUFFER_DEPTH and the FSM state enum typedef SHALL live in model_lstm_controller_pkg.
REQ-032 Buffer storage SHALL be one sub-module, model_vector_buffer (single write port, single registered-address read port).

Verification
REQ-033 Load 3,7,9; START SIZE_IN=3; DATA_ENABLE held 1 -> DATA_OUT 3,7,9 on alternate cycles, READY 1 cycle after last, LOAD_FULL 0.
REQ-034 Load 2 elements; START SIZE_IN=3 -> ERROR pulse 1 cycle, no DATA_OUT_ENABLE, FSM in IDLE; START SIZE_IN=0 -> ERROR.
REQ-035 Load 16 elements -> LOAD_FULL=1; 17th load ignored; START SIZE_IN=16 -> 16 elements, values 0..15 in order.
REQ-036 Load 5,6; DATA_ENABLE pulsed with 4-cycle gaps -> each element 1 cycle after its request, none duplicated or skipped.
REQ-037 RST low after first element of 4 -> outputs 0 immediately, no READY; reload 1 element, START SIZE_IN=1 -> correct single element, READY.
REQ-038 Load 1 element, then LOAD_ENABLE (value 4) with START SIZE_IN=2 same cycle -> accepted, elements sent in order.
